window_5x5_gen: RTL

WINDOW_5X5_GEN -- requirements
Module: window_5x5_gen

---
 rtl/window_5x5_gen.sv | 104 ++++++++++
 1 files changed

// File: rtl/window_5x5_gen.sv
// 5x5 sliding-window generator for a raster pixel stream.
// Four line buffers hold the previous lines; a 5x5 register window shifts left on
// each accepted pixel and emits a window whenever the completing pixel sits at
// row>=4 and col>=4, one clock after acceptance.
module window_5x5_gen #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int PIX_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PIX_W-1:0]      pix_in,
  input  logic                  pix_in_valid,
  input  logic                  sof,
  output logic [25*PIX_W-1:0]   win_out,
  output logic                  win_valid
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0] r_col, w_col_cur, w_col_nxt;
  logic [ROW_W-1:0] r_row, w_row_cur, w_row_nxt;

  // One word per column; slice k holds line (row-4+k), so slice 0 is the oldest line.
  logic [4*PIX_W-1:0] r_lb [IMG_WIDTH];
  logic [4*PIX_W-1:0] w_lb_rd;

  logic [PIX_W-1:0] r_win [25];
  logic             r_win_valid;
  logic             w_win_hit;

  // Effective position of this pixel (sof forces (0,0)) and the position after it.
  always_comb begin
    w_col_cur = sof ? '0 : r_col;
    w_row_cur = sof ? '0 : r_row;
    w_lb_rd   = r_lb[w_col_cur];
    w_win_hit = (w_row_cur >= ROW_W'(4)) && (w_col_cur >= COL_W'(4));
    w_col_nxt = w_col_cur + COL_W'(1);
    w_row_nxt = w_row_cur;
    if (w_col_cur == COL_LAST) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row_cur == ROW_LAST) ? '0 : w_row_cur + ROW_W'(1);
    end
  end

  // Position counters; a lone sof restarts the frame without consuming a pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (pix_in_valid) begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end else if (sof) begin
      r_col <= '0;
      r_row <= '0;
    end
  end

  // Line buffers cascade: each line moves one slot older, the new pixel enters slot 3.
  always_ff @(posedge clk) begin
    if (pix_in_valid) begin
      r_lb[w_col_cur] <= {pix_in, w_lb_rd[4*PIX_W-1:PIX_W]};
    end
  end

  // Window shift: columns move left, column 4 is loaded from the buffers and pix_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 25; k++) begin
        r_win[k] <= '0;
      end
    end else if (pix_in_valid) begin
      for (int rr = 0; rr < 5; rr++) begin
        for (int cc = 0; cc < 4; cc++) begin
          r_win[5*rr+cc] <= r_win[5*rr+cc+1];
        end
      end
      for (int rr = 0; rr < 4; rr++) begin
        r_win[5*rr+4] <= w_lb_rd[rr*PIX_W +: PIX_W];
      end
      r_win[24] <= pix_in;
    end
  end

  // Valid pulse follows an accepted pixel that completes an unpadded window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_valid <= 1'b0;
    end else begin
      r_win_valid <= pix_in_valid & w_win_hit;
    end
  end

  for (genvar k = 0; k < 25; k++) begin : g_flat
    assign win_out[PIX_W*k +: PIX_W] = r_win[k];
  end

  assign win_valid = r_win_valid;

endmodule
